// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: iterative AES InvSubBytes, LANES bytes substituted per clock
// Ports: clk; rst_n sync active-low; in_valid/in_ready/in_state accept a 128-bit state
// (byte 0 = [127:120]); out_valid/out_ready/out_state return the result; busy high in RUN/DONE.
// Optional: define SUB_BYTES_FWD_EN to add input fwd, latched at accept, selecting forward SubBytes.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  localparam logic [0:255][7:0] T = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign c = T[a];
endmodule

`ifdef SUB_BYTES_FWD_EN
module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  localparam logic [0:255][7:0] T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign c = T[a];
endmodule
`endif

module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef SUB_BYTES_FWD_EN
  input  logic         fwd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int GROUPS = 16 / LANES;
  localparam int CW = GROUPS > 1 ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st;
  logic [127:0] work, sh, nxt;
  logic [CW-1:0] cnt;
  logic [7:0] lane_a [LANES];
  logic [7:0] lane_c [LANES];
  logic [7:0] inv_c [LANES];
`ifdef SUB_BYTES_FWD_EN
  logic fwd_q;
`endif
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end
  assign sh = work << (int'(cnt) * 8 * LANES);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_a[l] = sh[127-8*l -: 8];
    inv_sbox u_inv (.a(lane_a[l]), .c(inv_c[l]));
`ifdef SUB_BYTES_FWD_EN
    logic [7:0] fwd_c;
    sbox u_fwd (.a(lane_a[l]), .c(fwd_c));
    assign lane_c[l] = fwd_q ? fwd_c : inv_c[l];
`else
    assign lane_c[l] = inv_c[l];
`endif
  end
  always_comb begin
    nxt = work;
    for (int i = 0; i < 16; i++)
      if (CW'(i / LANES) == cnt) nxt[127-8*i -: 8] = lane_c[i % LANES];
  end
  assign out_state = work;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      work      <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SUB_BYTES_FWD_EN
      fwd_q     <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          st       <= RUN;
          work     <= in_state;
          cnt      <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
`ifdef SUB_BYTES_FWD_EN
          fwd_q    <= fwd;
`endif
        end
        RUN: begin
          work <= nxt;
          cnt  <= cnt == LAST ? '0 : cnt + 1'b1;
          if (cnt == LAST) begin
            st        <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          st        <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: scoreboard bench for inv_sub_bytes_seq (LANES=4 main, plus 1/2/8/16 latency checks)
module tb_inv_sub_bytes_seq;
  localparam logic [127:0] ALL63 = {16{8'h63}};
  localparam logic [127:0] ALL52 = {16{8'h52}};
  localparam logic [127:0] C1_IN = 128'h7a9f1027_89d5f50b_2beffd9f_3dca4ea7;
  localparam logic [127:0] C1_EX = 128'hbd6e7c3d_f2b5779e_0b61216e_8b10b689;
  localparam logic [127:0] V3_IN = {4{32'h007ced16}};
  localparam logic [127:0] V3_EX = {4{32'h520153ff}};
  localparam int XL [4] = '{1, 2, 8, 16};
  localparam int XLAT [4] = '{17, 9, 3, 2};
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic out_ready = 0;
  logic [127:0] in_state = '0;
  logic in_ready, out_valid, busy;
  logic [127:0] out_state;
  logic fwd = 0;
  logic xv = 0;
  logic [3:0] xrdy, xov, xbusy;
  logic [127:0] xos [4];
  logic [127:0] exp_q [$];
  logic [127:0] e;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  inv_sub_bytes_seq #(.LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
`ifdef SUB_BYTES_FWD_EN
    .fwd(fwd),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );
  for (genvar g = 0; g < 4; g++) begin : g_x
    inv_sub_bytes_seq #(.LANES(XL[g])) u (
      .clk(clk), .rst_n(rst_n), .in_valid(xv), .in_ready(xrdy[g]), .in_state(C1_IN),
`ifdef SUB_BYTES_FWD_EN
      .fwd(1'b0),
`endif
      .out_valid(xov[g]), .out_ready(1'b1), .out_state(xos[g]), .busy(xbusy[g])
    );
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output got %h expected none", out_state);
      end else begin
        e = exp_q.pop_front();
        chk("out_state", out_state, e);
      end
    end
  task automatic send(input logic [127:0] d, input logic [127:0] ex, input bit push, input int exp_lat);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("in_ready_wait", 128'(in_ready), 128'(1));
    in_state = d;
    in_valid = 1;
    if (push) exp_q.push_back(ex);
    @(posedge clk); #1;
    in_valid = 0;
    k = 0;
    if (exp_lat > 0) begin
      while (!out_valid && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      chk("latency", 128'(k + 1), 128'(exp_lat));
    end
  endtask
  initial begin
    int k, idx, cyc, last;
    bit pre;
    int xlat [4];
    logic [127:0] xres [4];
    logic [127:0] bv [3];
    logic [127:0] be [3];
    bv = '{ALL63, C1_IN, 128'h0};
    be = '{128'h0, C1_EX, ALL52};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_state", out_state, 128'h0);
    rst_n = 1;
    out_ready = 1;
    send(ALL63, 128'h0, 1, 5);
    chk("busy_in_done", 128'(busy), 128'(1));
    chk("in_ready_in_done", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    chk("busy_after_hs", 128'(busy), 128'(0));
    chk("out_valid_after_hs", 128'(out_valid), 128'(0));
    chk("in_ready_after_hs", 128'(in_ready), 128'(1));
    send(C1_IN, C1_EX, 1, 5);
    @(posedge clk); #1;
    out_ready = 0;
    send(V3_IN, V3_EX, 1, 5);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      in_state = ~V3_IN;
      chk("hold_out_valid", 128'(out_valid), 128'(1));
      chk("hold_out_state", out_state, V3_EX);
      chk("hold_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("hold_release", 128'(out_valid), 128'(0));
    send({16{8'hff}}, 128'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("midrun_rst_in_ready", 128'(in_ready), 128'(1));
    chk("midrun_rst_out_valid", 128'(out_valid), 128'(0));
    chk("midrun_rst_out_state", out_state, 128'h0);
    chk("midrun_rst_busy", 128'(busy), 128'(0));
    send(128'h0, ALL52, 1, 5);
    @(posedge clk); #1;
    idx = 0;
    cyc = 0;
    last = -1;
    in_state = bv[0];
    in_valid = 1;
    while (idx < 3 && cyc < 100) begin
      pre = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (pre) begin
        exp_q.push_back(be[idx]);
        if (last >= 0) chk("accept_spacing", 128'(cyc - last), 128'(6));
        last = cyc;
        idx++;
        if (idx < 3) in_state = bv[idx];
      end
    end
    in_valid = 0;
    chk("b2b_accepts", 128'(idx), 128'(3));
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_drain", 128'(exp_q.size()), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    xlat = '{0, 0, 0, 0};
    xres = '{128'h0, 128'h0, 128'h0, 128'h0};
    xv = 1;
    @(posedge clk); #1;
    xv = 0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 4; j++)
        if (xov[j] && xlat[j] == 0) begin
          xlat[j] = c + 1;
          xres[j] = xos[j];
        end
    end
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("lanes%0d_latency", XL[j]), 128'(xlat[j]), 128'(XLAT[j]));
      chk($sformatf("lanes%0d_out_state", XL[j]), xres[j], C1_EX);
    end
`ifdef SUB_BYTES_FWD_EN
    fwd = 1;
    send(128'h0, ALL63, 1, 5);
    @(posedge clk); #1;
    fwd = 0;
    send(128'h0, ALL52, 1, 5);
    @(posedge clk); #1;
    fwd = 1;
    send(128'h0, ALL63, 1, 0);
    @(posedge clk); #1;
    fwd = 0;
    @(posedge clk); #1;
    fwd = 1;
    @(posedge clk); #1;
    fwd = 0;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("fwd_toggle_drain", 128'(exp_q.size()), 128'(0));
`endif
    repeat (10) @(posedge clk);
    #1;
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
